slc_control_unit: RTL and testbench
===================================

// Module: slc_control_unit
// PURPOSE
//  Sequencer for the 16-bit SLC datapath; the "driver" side of the ALU/register-file interface.
//  Moore FSM: fetches from memory, decodes IR, issues per-cycle load enables, bus gates, mux selects and the 3-bit ALU function code.
//  Sits between the top-level switches (Run/Continue) and the datapath registers, ALU, PC and MAR/MDR.
// PARAMETERS
//  MEM_WAIT   2   extra cycles each memory read/write is held before data is valid/committed (0..7)
// PORTS
//  Clk          in   1   single system clock, all state on rising edge
//  Reset        in   1   synchronous, active-high; dominates every other input
//  Run          in   1   start execution from HALT (level, sampled in HALT only)
//  Continue     in   1   resume from PAUSE (requires 1 then 0)
//  IR           in   16  instruction register contents
//  BEN          in   1   branch-enable from datapath (nzp & IR[11:9] != 0)
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED   out 1 each  register load strobes
//  GatePC, GateMDR, GateALU, GateMARMUX                          out 1 each  bus drivers, one-hot or all 0
//  PCMUX        out  2   00 PC+1, 01 bus, 10 adder
//  DRMUX, SR1MUX out 1   0 IR[11:9], 1 R7 (DR) / IR[8:6] (SR1)
//  SR2MUX       out  1   0 register, 1 sext(IR[4:0]) — driven from IR[5] in ADD/AND
//  ADDR1MUX     out  1   0 PC, 1 SR1
//  ADDR2MUX     out  2   00 zero, 01 off6, 10 off9, 11 off11
//  ALUK         out  3   ALU function: 000 add,001 sub,010 and,011 or,100 xor,101 not A,110 zero,111 pass A
//  Mem_CE, Mem_OE, Mem_WE  out 1 each  memory strobes, active-high
// BEHAVIOUR
//  Reset: state=HALT, wait counter=0; all strobes/gates/Mem_* =0, all selects=0, ALUK=000, next edge.
//  Outputs are pure decode of (state, IR); never registered, never glitch-gated by inputs.
//  HALT: Run=1 -> F1, else stay.
//  F1: GatePC, LD_MAR, PCMUX=00, LD_PC -> F2.
//  F2: Mem_CE, Mem_OE, counter counts 0..MEM_WAIT; on last cycle LD_MDR -> F3. MEM_WAIT=0 => one cycle.
//  F3: GateMDR, LD_IR -> DEC.  DEC: LD_BEN; branch on IR[15:12]:
//   0001 ADD: SR1MUX=1,GateALU,ALUK=000,LD_REG,LD_CC -> F1
//   0101 AND: same, ALUK=010.  1001 NOT: ALUK=101, SR2 ignored -> F1
//   0000 BR : BEN=1 -> BR_T (ADDR1=PC,ADDR2=10,PCMUX=10,LD_PC) -> F1; BEN=0 -> F1
//   1100 JMP: SR1MUX=1,ALUK=111,GateALU,PCMUX=01,LD_PC -> F1
//   0100 JSR: JSR1 (GatePC,DRMUX=1,LD_REG) -> JSR2 (ADDR1=PC,ADDR2=11,PCMUX=10,LD_PC) -> F1
//   0110 LDR: LDR1 (ADDR1=SR1,ADDR2=01,GateMARMUX,LD_MAR) -> LDR2 (read wait as F2)
//             -> LDR3 (GateMDR,LD_REG,LD_CC) -> F1
//   0111 STR: STR1 (addr->MAR) -> STR2 (SR1MUX=0 reads IR[11:9],ALUK=111,GateALU,LD_MDR)
//             -> STR3 (Mem_CE,Mem_WE held MEM_WAIT+1 cycles) -> F1
//   1101 PAUSE: P1 (LD_LED) hold while Continue=0; Continue=1 -> P2; P2 hold while Continue=1; 0 -> F1
//   any other opcode: NOP, -> F1 (no loads)
//  Counter: 3-bit, cleared on every wait-state entry and on Reset; saturates, never wraps.
//  Reset mid-STR3 drops Mem_WE same edge; partial write is the memory's problem, not retried.
//  Run/Continue ignored outside HALT/P1/P2. At most one Gate* high in any state.
// STRUCTURE
//  slc_pkg: opcode_t enum, alu_op_t (8 codes above — ALU encoding is owned here), state_t enum,
//   PCMUX/ADDR2MUX localparams. Shared with datapath and ALU.
//  Sub-module mem_wait_timer (Clk, Reset, start, done) generates the MEM_WAIT count; FSM in one
//   always_ff for state, one always_comb for next-state and default-zero output decode.
// TESTING
//  Reset held 3 cycles mid-F2 -> state HALT, every output 0 on next edge; Run=0 keeps HALT.
//  Run=1, IR=16'h1283 (ADD R1,R2,R3), MEM_WAIT=2 -> F1,F2x3,F3,DEC,ADD: 7 cycles, ALUK=000,
//   SR2MUX=0, LD_REG/LD_CC high exactly one cycle.
//  IR=16'h0402 (BRz): BEN=1 -> BR_T LD_PC, PCMUX=10, ADDR2=10; BEN=0 -> DEC then F1, LD_PC low.
//  IR=16'h7042 (STR R0,R1,2) -> MAR load, LD_MDR w/ ALUK=111, Mem_WE high 3 cycles, Mem_OE low.
//  IR=16'hD0FF (PAUSE) -> LD_LED; Continue 0->1->0 required; Continue stuck 1 stays in P2.
//  IR=16'hF025 (unused) -> F1 next cycle, no LD_* asserted; Gate* one-hot checked by assertion.

Source files
------------

// File: rtl/slc_pkg.sv
// Shared SLC types: opcodes, ALU function codes, control-unit states and mux encodings.
package slc_pkg;

    typedef enum logic [3:0] {
        OP_BR    = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_JSR   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_LDR   = 4'b0110,
        OP_STR   = 4'b0111,
        OP_NOT   = 4'b1001,
        OP_JMP   = 4'b1100,
        OP_PAUSE = 4'b1101
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOTA = 3'b101,
        ALU_ZERO = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_t;

    typedef enum logic [4:0] {
        S_HALT, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT, S_BR_T, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_P1, S_P2
    } state_t;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // States that hold a memory strobe for MEM_WAIT+1 cycles.
    function automatic logic is_wait_state(state_t s);
        return (s == S_F2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/slc_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle; master is the sequencer side.
interface slc_control_unit_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic [2:0]  ALUK;
    logic        Mem_CE, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, IR, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_CE, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, IR, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_CE, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/slc_control_unit_mem_wait_timer.sv
// Saturating 3-bit wait counter; done marks the final cycle of a memory access.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic done
);
    localparam logic [2:0] LAST = 3'(MEM_WAIT);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 3'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == LAST);
endmodule

// File: rtl/slc_control_unit.sv
// SLC sequencer: Moore FSM decoding (state, IR) into load strobes, gates, selects and memory strobes.
module slc_control_unit
    import slc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    slc_control_unit_if.master ctl
);
    state_t state_q, state_d;
    logic   wait_start, wait_done;

    // Counter is cleared on the edge that enters any wait state.
    assign wait_start = is_wait_state(state_d) && !is_wait_state(state_q);

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .start (wait_start),
        .done  (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= S_HALT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        ctl.LD_MAR     = 1'b0;
        ctl.LD_MDR     = 1'b0;
        ctl.LD_IR      = 1'b0;
        ctl.LD_BEN     = 1'b0;
        ctl.LD_CC      = 1'b0;
        ctl.LD_REG     = 1'b0;
        ctl.LD_PC      = 1'b0;
        ctl.LD_LED     = 1'b0;
        ctl.GatePC     = 1'b0;
        ctl.GateMDR    = 1'b0;
        ctl.GateALU    = 1'b0;
        ctl.GateMARMUX = 1'b0;
        ctl.PCMUX      = PCMUX_INC;
        ctl.DRMUX      = 1'b0;
        ctl.SR1MUX     = 1'b0;
        ctl.SR2MUX     = 1'b0;
        ctl.ADDR1MUX   = 1'b0;
        ctl.ADDR2MUX   = ADDR2_ZERO;
        ctl.ALUK       = ALU_ADD;
        ctl.Mem_CE     = 1'b0;
        ctl.Mem_OE     = 1'b0;
        ctl.Mem_WE     = 1'b0;

        case (state_q)
            S_HALT: if (ctl.Run) state_d = S_F1;
            S_F1: begin
                ctl.GatePC = 1'b1;
                ctl.LD_MAR = 1'b1;
                ctl.LD_PC  = 1'b1;
                state_d    = S_F2;
            end
            S_F2, S_LDR2: begin
                ctl.Mem_CE = 1'b1;
                ctl.Mem_OE = 1'b1;
                if (wait_done) begin
                    ctl.LD_MDR = 1'b1;
                    state_d    = (state_q == S_F2) ? S_F3 : S_LDR3;
                end
            end
            S_F3: begin
                ctl.GateMDR = 1'b1;
                ctl.LD_IR   = 1'b1;
                state_d     = S_DEC;
            end
            S_DEC: begin
                ctl.LD_BEN = 1'b1;
                case (ctl.IR[15:12])
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = ctl.BEN ? S_BR_T : S_F1;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR1;
                    OP_LDR:   state_d = S_LDR1;
                    OP_STR:   state_d = S_STR1;
                    OP_PAUSE: state_d = S_P1;
                    default:  state_d = S_F1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                ctl.SR1MUX  = 1'b1;
                ctl.SR2MUX  = (state_q == S_NOT) ? 1'b0 : ctl.IR[5];
                ctl.GateALU = 1'b1;
                ctl.ALUK    = (state_q == S_ADD) ? ALU_ADD :
                              (state_q == S_AND) ? ALU_AND : ALU_NOTA;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
                state_d     = S_F1;
            end
            S_BR_T, S_JSR2: begin
                ctl.ADDR2MUX = (state_q == S_BR_T) ? ADDR2_OFF9 : ADDR2_OFF11;
                ctl.PCMUX    = PCMUX_ADDER;
                ctl.LD_PC    = 1'b1;
                state_d      = S_F1;
            end
            S_JMP: begin
                ctl.SR1MUX  = 1'b1;
                ctl.ALUK    = ALU_PASS;
                ctl.GateALU = 1'b1;
                ctl.PCMUX   = PCMUX_BUS;
                ctl.LD_PC   = 1'b1;
                state_d     = S_F1;
            end
            S_JSR1: begin
                ctl.GatePC = 1'b1;
                ctl.DRMUX  = 1'b1;
                ctl.LD_REG = 1'b1;
                state_d    = S_JSR2;
            end
            S_LDR1, S_STR1: begin
                ctl.SR1MUX     = 1'b1;
                ctl.ADDR1MUX   = 1'b1;
                ctl.ADDR2MUX   = ADDR2_OFF6;
                ctl.GateMARMUX = 1'b1;
                ctl.LD_MAR     = 1'b1;
                state_d        = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                ctl.GateMDR = 1'b1;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
                state_d     = S_F1;
            end
            S_STR2: begin
                ctl.ALUK    = ALU_PASS;
                ctl.GateALU = 1'b1;
                ctl.LD_MDR  = 1'b1;
                state_d     = S_STR3;
            end
            S_STR3: begin
                ctl.Mem_CE = 1'b1;
                ctl.Mem_WE = 1'b1;
                if (wait_done) state_d = S_F1;
            end
            S_P1: begin
                ctl.LD_LED = 1'b1;
                if (ctl.Continue) state_d = S_P2;
            end
            S_P2: if (!ctl.Continue) state_d = S_F1;
            default: state_d = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_slc_control_unit.sv
// Scoreboard bench: expected per-cycle control words queued with stimulus, compared at negedge.
module tb_slc_control_unit;
    import slc_pkg::*;

    localparam int unsigned MW = 2;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [2:0] aluk;
        logic       mem_ce, mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        string tag;
        ctl_t  v;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    slc_control_unit_if bus ();

    slc_control_unit #(.MEM_WAIT(MW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .ctl   (bus)
    );

    always #5 Clk = ~Clk;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t o;
        o.ld_mar = bus.LD_MAR;   o.ld_mdr = bus.LD_MDR;   o.ld_ir = bus.LD_IR;
        o.ld_ben = bus.LD_BEN;   o.ld_cc = bus.LD_CC;     o.ld_reg = bus.LD_REG;
        o.ld_pc = bus.LD_PC;     o.ld_led = bus.LD_LED;
        o.gate_pc = bus.GatePC;  o.gate_mdr = bus.GateMDR;
        o.gate_alu = bus.GateALU; o.gate_marmux = bus.GateMARMUX;
        o.pcmux = bus.PCMUX;     o.drmux = bus.DRMUX;     o.sr1mux = bus.SR1MUX;
        o.sr2mux = bus.SR2MUX;   o.addr1mux = bus.ADDR1MUX; o.addr2mux = bus.ADDR2MUX;
        o.aluk = bus.ALUK;       o.mem_ce = bus.Mem_CE;   o.mem_oe = bus.Mem_OE;
        o.mem_we = bus.Mem_WE;
        return o;
    endfunction

    task automatic push(input string tag, input ctl_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // One cycle per queued entry, so the wait is bounded by the queue length.
    task automatic drain();
        exp_t e;
        ctl_t o;
        while (sb.size() > 0) begin
            @(negedge Clk);
            e = sb.pop_front();
            o = observe();
            check_eq(e.tag, 32'(o), 32'(e.v));
            check_eq({e.tag, "_gate1h"},
                     32'($countones({o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux}) > 1), 32'd0);
        end
    endtask

    function automatic ctl_t v_f1();
        ctl_t e = '0;
        e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; e.pcmux = 2'b00;
        return e;
    endfunction

    function automatic ctl_t v_rd(input logic last);
        ctl_t e = '0;
        e.mem_ce = 1'b1; e.mem_oe = 1'b1; e.ld_mdr = last;
        return e;
    endfunction

    function automatic ctl_t v_addr6();
        ctl_t e = '0;
        e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
        e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
        return e;
    endfunction

    function automatic ctl_t v_alu(input logic [2:0] k, input logic sr2);
        ctl_t e = '0;
        e.sr1mux = 1'b1; e.gate_alu = 1'b1; e.aluk = k; e.sr2mux = sr2;
        e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        return e;
    endfunction

    task automatic push_read(input string tag);
        for (int unsigned i = 0; i < MW; i++) push(tag, v_rd(1'b0));
        push({tag, "_last"}, v_rd(1'b1));
    endtask

    task automatic start_instr(input logic [15:0] ir, input logic ben);
        ctl_t e;
        Reset = 1'b1;
        bus.Run = 1'b0;
        push("pre_reset", '0);
        drain();
        Reset = 1'b0;
        bus.IR = ir;
        bus.BEN = ben;
        bus.Run = 1'b1;
        push("f1", v_f1());
        push_read("f2");
        e = '0; e.gate_mdr = 1'b1; e.ld_ir = 1'b1;
        push("f3", e);
        e = '0; e.ld_ben = 1'b1;
        push("dec", e);
    endtask

    initial begin
        ctl_t e;
        bus.Run = 1'b0;
        bus.Continue = 1'b0;
        bus.IR = 16'h0000;
        bus.BEN = 1'b0;

        for (int i = 0; i < 3; i++) push("reset", '0);
        drain();
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) push("halt_run0", '0);
        drain();

        // ADD R1,R2,R3: 7 cycles then back to F1
        start_instr(16'h1283, 1'b0);
        push("add", v_alu(3'b000, 1'b0));
        push("add_f1", v_f1());
        drain();
        bus.Run = 1'b0;

        // Reset held 3 cycles while in F2
        push("f2_first", v_rd(1'b0));
        drain();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) push("rst_mid_f2", '0);
        drain();
        Reset = 1'b0;
        push("halt_after_rst", '0);
        drain();

        start_instr(16'h5262, 1'b0);
        push("and_imm", v_alu(3'b010, 1'b1));
        push("and_f1", v_f1());
        drain();

        start_instr(16'h927F, 1'b0);
        push("not", v_alu(3'b101, 1'b0));
        push("not_f1", v_f1());
        drain();

        start_instr(16'h0402, 1'b1);
        e = '0; e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1'b1;
        push("br_taken", e);
        push("br_t_f1", v_f1());
        drain();

        start_instr(16'h0402, 1'b0);
        push("br_not_f1", v_f1());
        drain();

        start_instr(16'hC080, 1'b0);
        e = '0; e.sr1mux = 1'b1; e.aluk = 3'b111; e.gate_alu = 1'b1;
        e.pcmux = 2'b01; e.ld_pc = 1'b1;
        push("jmp", e);
        push("jmp_f1", v_f1());
        drain();

        start_instr(16'h4802, 1'b0);
        e = '0; e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1;
        push("jsr1", e);
        e = '0; e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1'b1;
        push("jsr2", e);
        push("jsr_f1", v_f1());
        drain();

        start_instr(16'h6242, 1'b0);
        push("ldr1", v_addr6());
        push_read("ldr2");
        e = '0; e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        push("ldr3", e);
        push("ldr_f1", v_f1());
        drain();

        start_instr(16'h7042, 1'b0);
        push("str1", v_addr6());
        e = '0; e.aluk = 3'b111; e.gate_alu = 1'b1; e.ld_mdr = 1'b1;
        push("str2", e);
        e = '0; e.mem_ce = 1'b1; e.mem_we = 1'b1;
        for (int unsigned i = 0; i <= MW; i++) push("str3", e);
        push("str_f1", v_f1());
        drain();

        // Reset in the first STR3 cycle drops the write strobe on the next edge
        start_instr(16'h7042, 1'b0);
        push("str1b", v_addr6());
        e = '0; e.aluk = 3'b111; e.gate_alu = 1'b1; e.ld_mdr = 1'b1;
        push("str2b", e);
        e = '0; e.mem_ce = 1'b1; e.mem_we = 1'b1;
        push("str3b", e);
        drain();
        Reset = 1'b1;
        push("rst_mid_str3", '0);
        drain();
        Reset = 1'b0;
        bus.Run = 1'b0;
        push("halt_after_str3", '0);
        drain();

        start_instr(16'hD0FF, 1'b0);
        bus.Continue = 1'b0;
        e = '0; e.ld_led = 1'b1;
        for (int i = 0; i < 3; i++) push("p1_hold", e);
        drain();
        bus.Run = 1'b0;
        bus.Continue = 1'b1;
        for (int i = 0; i < 3; i++) push("p2_stuck", '0);
        drain();
        bus.Continue = 1'b0;
        push("pause_f1", v_f1());
        drain();

        start_instr(16'hF025, 1'b0);
        push("unused_f1", v_f1());
        drain();
        bus.Run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
